// File: rtl/buffer_pkgs.sv
// Shared types for the decode queue stage: fetch/decode payloads, micro-op enums
// and RV32 opcode constants.
package buffer_pkgs;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLTU, ALU_OR, ALU_AND, ALU_SRL, ALU_SRA, ALU_EQ, ALU_NE
  } aluop_t;

  typedef enum logic [1:0] {FU_ALU, FU_MEM, FU_BRANCH} func_u_t;

  typedef enum logic [2:0] {LS_NONE, LS_LW, LS_LBU, LS_SW, LS_SH} ls_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  // pc_rel marks auipc, whose first operand is the pc rather than zero like lui
  typedef struct packed {
    logic [31:0] pc;
    aluop_t      aluop;
    func_u_t     func_u;
    ls_type_t    ls_type;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
    logic        imm_used;
    logic        load_store;
    logic        branch;
    logic        jump;
    logic        pc_rel;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/decode_queue_stage_if.sv
// Producer/consumer handshake bundle for the decode queue stage.
interface decode_queue_stage_if
  import buffer_pkgs::*;
#(
  parameter type F     = fetch_t,
  parameter type D     = decode_t,
  parameter int  DEPTH = 4
);
  logic                     valid_prod_i;
  logic                     ready_prod_o;
  F                         data_i;
  logic                     ready_cons_i;
  logic                     valid_cons_o;
  D                         data_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output valid_prod_i, data_i, ready_cons_i,
    input  ready_prod_o, valid_cons_o, data_o, count_o
  );

  modport slave (
    input  valid_prod_i, data_i, ready_cons_i,
    output ready_prod_o, valid_cons_o, data_o, count_o
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32 subset decoder; unsupported words come out as an
// illegal-marked record with every operand field cleared.
module decode_logic
  import buffer_pkgs::*;
(
  input  fetch_t  fetch,
  output decode_t dec
);
  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic        ok, use_rs1, use_rs2, use_rd, use_imm;

  assign instr = fetch.instr;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.pc      = fetch.pc;
    dec.aluop   = ALU_ADD;
    dec.func_u  = FU_ALU;
    dec.ls_type = LS_NONE;
    ok          = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    use_imm     = 1'b0;
    imm         = '0;
    case (opc)
      OPC_LOAD: begin
        ok = (f3 == 3'b010) || (f3 == 3'b100);
        dec.func_u = FU_MEM;
        dec.load_store = 1'b1;
        dec.ls_type = (f3 == 3'b010) ? LS_LW : LS_LBU;
        use_rs1 = 1'b1; use_rd = 1'b1; use_imm = 1'b1; imm = imm_i;
      end
      OPC_STORE: begin
        ok = (f3 == 3'b010) || (f3 == 3'b001);
        dec.func_u = FU_MEM;
        dec.load_store = 1'b1;
        dec.ls_type = (f3 == 3'b010) ? LS_SW : LS_SH;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b1; imm = imm_s;
      end
      OPC_BRANCH: begin
        ok = (f3 == 3'b000) || (f3 == 3'b001);
        dec.func_u = FU_BRANCH;
        dec.branch = 1'b1;
        dec.aluop = f3[0] ? ALU_NE : ALU_EQ;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b1; imm = imm_b;
      end
      OPC_JAL: begin
        ok = 1'b1;
        dec.func_u = FU_BRANCH;
        dec.jump = 1'b1;
        use_rd = 1'b1; use_imm = 1'b1; imm = imm_j;
      end
      OPC_JALR: begin
        ok = (f3 == 3'b000);
        dec.func_u = FU_BRANCH;
        dec.jump = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1; use_imm = 1'b1; imm = imm_i;
      end
      OPC_LUI: begin
        ok = 1'b1;
        use_rd = 1'b1; use_imm = 1'b1; imm = imm_u;
      end
      OPC_AUIPC: begin
        ok = 1'b1;
        dec.pc_rel = 1'b1;
        use_rd = 1'b1; use_imm = 1'b1; imm = imm_u;
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; use_imm = 1'b1; imm = imm_i;
        case (f3)
          3'b000:  begin ok = 1'b1; dec.aluop = ALU_ADD;  end
          3'b011:  begin ok = 1'b1; dec.aluop = ALU_SLTU; end
          3'b110:  begin ok = 1'b1; dec.aluop = ALU_OR;   end
          default: ok = 1'b0;
        endcase
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        case (f3)
          3'b000: begin
            ok = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec.aluop = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            ok = (f7 == F7_BASE);
            dec.aluop = ALU_AND;
          end
          3'b101: begin
            ok = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec.aluop = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase

    dec.rs1      = use_rs1 ? instr[19:15] : 5'd0;
    dec.rs2      = use_rs2 ? instr[24:20] : 5'd0;
    dec.rd       = use_rd  ? instr[11:7]  : 5'd0;
    dec.rs1_used = use_rs1;
    dec.rs2_used = use_rs2;
    dec.rd_used  = use_rd && (instr[11:7] != 5'd0);
    dec.imm_used = use_imm;
    dec.imm      = imm;

    if (!ok) begin
      dec         = '0;
      dec.pc      = fetch.pc;
      dec.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage with a DEPTH-entry output queue. Build macro DECODE_ILLEGAL_TRAP_EN:
// defined -> unsupported words are queued as illegal; undefined -> they are dropped.
module decode_queue_stage
  import buffer_pkgs::*;
#(
  parameter type F     = fetch_t,
  parameter type D     = decode_t,
  parameter int  DEPTH = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  input logic                  flush_i,
  decode_queue_stage_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  D              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  F              fetch_w;
  D              dec;
  logic          accept, enq_ok, push, pop;

  assign fetch_w = q.data_i;

  decode_logic u_decode (
    .fetch (fetch_w),
    .dec   (dec)
  );

  assign q.ready_prod_o = (count < CW'(DEPTH));
  assign q.valid_cons_o = (count != '0);
  assign q.count_o      = count;
  assign q.data_o       = mem[rd_ptr];

  assign accept = q.valid_prod_i & q.ready_prod_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign enq_ok = 1'b1;
`else
  // unsupported words still handshake upstream so fetch is never stalled by them
  assign enq_ok = ~dec.illegal;
`endif
  assign push = accept & enq_ok;
  assign pop  = q.valid_cons_o & q.ready_cons_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !reset_i && !flush_i) mem[wr_ptr] <= dec;
  end
endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage: decode vector table plus queue
// full/flush/reset/unsupported-word sequences.
module tb_decode_queue_stage;
  import buffer_pkgs::*;

  logic clk_i = 1'b0;
  logic reset_i, flush_i;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  decode_queue_stage_if #(.DEPTH(4)) q ();

  decode_queue_stage #(.DEPTH(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .q       (q)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    decode_t     exp;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string name, input decode_t act, input decode_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // used = {rs1,rs2,rd,imm}, flg = {load_store,branch,jump,pc_rel}
  function automatic decode_t mk(aluop_t a, func_u_t fu, ls_type_t ls, logic [31:0] imm,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic [3:0] used, logic [3:0] flg);
    decode_t d;
    d = '0;
    d.aluop = a;
    d.func_u = fu;
    d.ls_type = ls;
    d.imm = imm;
    d.rs1 = rs1;
    d.rs2 = rs2;
    d.rd = rd;
    {d.rs1_used, d.rs2_used, d.rd_used, d.imm_used} = used;
    {d.load_store, d.branch, d.jump, d.pc_rel} = flg;
    return d;
  endfunction

  function automatic fetch_t addi_word(int k);
    fetch_t f;
    f.pc = 32'h2000 + 32'(k * 4);
    f.instr = {12'(k), 20'h00093};
    return f;
  endfunction

  task automatic push_word(input fetch_t f);
    q.valid_prod_i = 1'b1;
    q.data_i = f;
    step();
    q.valid_prod_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"addi",  32'h00510093, mk(ALU_ADD,  FU_ALU,    LS_NONE, 32'd5,        5'd2, 5'd0, 5'd1,  4'b1011, 4'b0000)};
    vecs[1]  = '{"sub",   32'h402081B3, mk(ALU_SUB,  FU_ALU,    LS_NONE, 32'd0,        5'd1, 5'd2, 5'd3,  4'b1110, 4'b0000)};
    vecs[2]  = '{"bne",   32'hFE209EE3, mk(ALU_NE,   FU_BRANCH, LS_NONE, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0,  4'b1101, 4'b0100)};
    vecs[3]  = '{"lw",    32'h00832283, mk(ALU_ADD,  FU_MEM,    LS_LW,   32'd8,        5'd6, 5'd0, 5'd5,  4'b1011, 4'b1000)};
    vecs[4]  = '{"sw",    32'hFE712E23, mk(ALU_ADD,  FU_MEM,    LS_SW,   32'hFFFFFFFC, 5'd2, 5'd7, 5'd0,  4'b1101, 4'b1000)};
    vecs[5]  = '{"lui",   32'h12345537, mk(ALU_ADD,  FU_ALU,    LS_NONE, 32'h12345000, 5'd0, 5'd0, 5'd10, 4'b0011, 4'b0000)};
    vecs[6]  = '{"jal",   32'h008000EF, mk(ALU_ADD,  FU_BRANCH, LS_NONE, 32'd8,        5'd0, 5'd0, 5'd1,  4'b0011, 4'b0010)};
    vecs[7]  = '{"sra",   32'h4062D233, mk(ALU_SRA,  FU_ALU,    LS_NONE, 32'd0,        5'd5, 5'd6, 5'd4,  4'b1110, 4'b0000)};
    vecs[8]  = '{"nop",   32'h00000013, mk(ALU_ADD,  FU_ALU,    LS_NONE, 32'd0,        5'd0, 5'd0, 5'd0,  4'b1001, 4'b0000)};
    vecs[9]  = '{"sltiu", 32'hFFF1B113, mk(ALU_SLTU, FU_ALU,    LS_NONE, 32'hFFFFFFFF, 5'd3, 5'd0, 5'd2,  4'b1011, 4'b0000)};
    vecs[10] = '{"auipc", 32'h00001297, mk(ALU_ADD,  FU_ALU,    LS_NONE, 32'h00001000, 5'd0, 5'd0, 5'd5,  4'b0011, 4'b0001)};

    reset_i = 1'b1;
    flush_i = 1'b0;
    q.valid_prod_i = 1'b0;
    q.ready_cons_i = 1'b0;
    q.data_i = '0;
    step();
    step();
    reset_i = 1'b0;
    chk("reset_count", q.count_o, 0);
    chk("reset_valid", q.valid_cons_o, 0);
    chk("reset_ready", q.ready_prod_o, 1);

    // single-word decode with one-cycle latency into an empty queue
    for (int i = 0; i < 11; i++) begin
      decode_t e;
      fetch_t  f;
      f.pc = 32'h1000 + 32'(i * 4);
      f.instr = vecs[i].instr;
      e = vecs[i].exp;
      e.pc = f.pc;
      q.ready_cons_i = 1'b0;
      push_word(f);
      chk({vecs[i].name, "_valid"}, q.valid_cons_o, 1);
      chk_dec({vecs[i].name, "_dec"}, q.data_o, e);
      q.ready_cons_i = 1'b1;
      step();
      q.ready_cons_i = 1'b0;
      chk({vecs[i].name, "_drain"}, q.count_o, 0);
    end

    // fill to DEPTH with the consumer stalled; fifth word must be held
    q.ready_cons_i = 1'b0;
    q.valid_prod_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      q.data_i = addi_word(k);
      if (k < 5) step();
    end
    step();
    chk("full_count", q.count_o, 4);
    chk("full_ready", q.ready_prod_o, 0);
    chk("full_head", q.data_o.imm, 1);
    q.ready_cons_i = 1'b1;
    step();
    chk("pop_count", q.count_o, 3);
    chk("pop_head", q.data_o.imm, 2);
    chk("pop_ready", q.ready_prod_o, 1);
    step();
    chk("pushpop_count", q.count_o, 3);
    chk("pushpop_head", q.data_o.imm, 3);
    q.valid_prod_i = 1'b0;
    for (int k = 4; k <= 5; k++) begin
      step();
      chk("order_head", q.data_o.imm, 32'(k));
    end
    step();
    chk("empty_count", q.count_o, 0);
    chk("empty_valid", q.valid_cons_o, 0);
    q.ready_cons_i = 1'b0;

    // flush with a word presented in the same cycle
    for (int k = 11; k <= 13; k++) push_word(addi_word(k));
    chk("preflush_count", q.count_o, 3);
    flush_i = 1'b1;
    q.valid_prod_i = 1'b1;
    q.data_i = addi_word(99);
    step();
    flush_i = 1'b0;
    q.valid_prod_i = 1'b0;
    chk("flush_count", q.count_o, 0);
    chk("flush_valid", q.valid_cons_o, 0);
    step();
    chk("flush_stays_empty", q.count_o, 0);
    push_word(addi_word(20));
    chk("postflush_count", q.count_o, 1);
    chk("postflush_head", q.data_o.imm, 20);

    // reset mid-operation overrides handshakes
    push_word(addi_word(21));
    reset_i = 1'b1;
    q.valid_prod_i = 1'b1;
    q.ready_cons_i = 1'b1;
    q.data_i = addi_word(22);
    step();
    reset_i = 1'b0;
    q.valid_prod_i = 1'b0;
    q.ready_cons_i = 1'b0;
    chk("midreset_count", q.count_o, 0);
    chk("midreset_ready", q.ready_prod_o, 1);

    // unsupported words: all-ones and an R-type with a foreign funct7
    push_word(addi_word(7));
    chk("unsup_ready_before", q.ready_prod_o, 1);
    push_word('{pc: 32'h3000, instr: 32'hFFFFFFFF});
    push_word('{pc: 32'h3004, instr: 32'h02208133});
    chk("unsup_ready_after", q.ready_prod_o, 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("unsup_count", q.count_o, 3);
    q.ready_cons_i = 1'b1;
    step();
    chk_dec("unsup_entry", q.data_o, '{pc: 32'h3000, illegal: 1'b1, default: '0});
    step();
    step();
    q.ready_cons_i = 1'b0;
`else
    chk("unsup_count", q.count_o, 1);
    q.ready_cons_i = 1'b1;
    step();
    q.ready_cons_i = 1'b0;
`endif
    chk("unsup_drain", q.count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
